btb_assoc_predictor: RTL
========================

Name: btb_assoc_predictor

Overview:
- Parametrised set-associative BHT/BTB for the ARM pipeline; successor to the direct-mapped, tagless predictor.
- Fetch stage looks up PC_F combinationally and gets a taken/not-taken prediction plus the branch target address (BTA).
- Execute stage writes back every resolved branch.
- Adds tags, valid bits, N ways, pseudo-LRU replacement, true saturating counters and a synchronous flush.

Parameters:
- ENTRY_BITS, 4, set index width; SETS = 2**ENTRY_BITS; index = PC[ENTRY_BITS+1:2].
- WAYS, 2, associativity; legal values 1, 2, 4.
- PRD_BITS, 2, counter width; MSB=1 predicts taken.
- TAG_BITS, 30-ENTRY_BITS, tag = PC[31:ENTRY_BITS+2]; fixed by ENTRY_BITS, not overridable.

Ports:
- clk  input  1  clock
- RESET  input  1  reset, asynchronous, active-high
- PC_F  input  32  fetch PC
- PrPCSrc_F  output  1  predicted taken (hit and counter MSB=1)
- PrALUResult_F  output  32  predicted BTA; 0 when PrPCSrc_F=0
- PrHit_F  output  1  tag hit in some valid way
- Upd_E  input  1  resolved branch in E this cycle
- PC_E  input  32  PC of the resolved branch
- PCSrc_E  input  1  actual outcome, 1=taken
- ALUResult_E  input  32  actual BTA
- Flush  input  1  synchronous invalidate-all

Behaviour:
- Reset: all valid bits=0, counters=01, TAs=0, PLRU bits=0. Outputs therefore PrHit_F=0, PrPCSrc_F=0, PrALUResult_F=0.
- Lookup: purely combinational, zero latency. Hit = valid & tag match in a way.
  - Multiple matches must not occur. If they do, the lowest-index way wins.
- Counter encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken. Saturating ±1 per update: taken increments, not-taken decrements.
- Update on Upd_E=1, one cycle, at posedge:
  - Hit in set(PC_E): update that way's counter. If PCSrc_E=1, write ALUResult_E to its TA. Mark the way most-recently-used.
  - Miss and PCSrc_E=1: allocate a victim. Choose the lowest-index invalid way, else the PLRU victim.
    - Write tag, valid=1, TA=ALUResult_E, counter=10.
    - Mark the victim most-recently-used.
  - Miss and PCSrc_E=0: no state change.
- PLRU:
  - Tree of WAYS-1 bits per set.
  - WAYS=1: no PLRU storage; the victim is always way 0.
  - Updated only by E-stage hits and allocations, never by fetch lookups.
- Same-set read/write in one cycle: fetch sees pre-update contents (read-before-write). No bypass.
- Flush=1: clears all valid bits at the next edge. Counters, TAs and PLRU bits are left unchanged.
  - Flush takes priority over a simultaneous Upd_E; the update is dropped.
- RESET asserted mid-operation: state clears immediately and asynchronously. Outputs go to their reset values in the same cycle.
- Upd_E=0: no state change, whatever the other E inputs are.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined, adds three 32-bit outputs, each saturating at 0xFFFFFFFF:
  - PerfUpd: count of Upd_E cycles.
  - PerfHit: count of updates that hit.
  - PerfAlloc: count of allocations.
- Counters clear on RESET and do not clear on Flush. An update dropped by Flush is not counted.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - Counter encoding localparams (CNT_SNT, CNT_WNT, CNT_WT, CNT_ST).
  - CNT_ALLOC_INIT=10 and CNT_RESET=01.
  - A saturating-increment/decrement function.
- Sub-module bp_plru: one set's PLRU state.
  - Inputs: access valid, accessed way.
  - Output: victim way.
  - Parametrised by WAYS; instantiated SETS times via generate.

Test Plan:
- Reset, then PC_F=0x100 -> PrHit_F=0, PrPCSrc_F=0, PrALUResult_F=0.
- Upd_E with PC_E=0x100, PCSrc_E=1, ALUResult_E=0x200; next cycle PC_F=0x100 -> PrHit_F=1, PrPCSrc_F=1, PrALUResult_F=0x200 (counter 10).
- Same branch with PCSrc_E=0 twice -> counter goes 10->01->00, PrPCSrc_F=0, PrHit_F=1. Three further taken updates -> 01, 10, 11 and holds at 11 on a fourth.
- WAYS=2, ENTRY_BITS=4: allocate PCs 0x100, 0x500, then a hit update on 0x100, then allocate 0x900 (all set 0) -> 0x500 evicted. 0x100 and 0x900 hit, 0x500 misses.
- Flush asserted with a simultaneous allocating Upd_E -> all lookups miss next cycle and the update is not installed.
- In the same cycle, PC_F=PC_E=0x100 with an allocating Upd_E -> PrHit_F=0 that cycle and PrHit_F=1 the next. With BP_PERF_CNT_EN defined, PerfAlloc increments by 1.

Source files
------------

// File: rtl/btb_assoc_predictor_pkg.sv
// rtl/btb_assoc_predictor_pkg.sv - bp_pkg: counter encodings and helpers shared by the predictor
// Optional build macro used elsewhere in the bundle: BP_PERF_CNT_EN
package bp_pkg;

   localparam logic [1:0] CNT_SNT        = 2'b00;
   localparam logic [1:0] CNT_WNT        = 2'b01;
   localparam logic [1:0] CNT_WT         = 2'b10;
   localparam logic [1:0] CNT_ST         = 2'b11;
   localparam logic [1:0] CNT_ALLOC_INIT = CNT_WT;
   localparam logic [1:0] CNT_RESET      = CNT_WNT;

   // Saturating step on a zero-extended counter: up increments, otherwise decrements.
   function automatic logic [7:0] cnt_sat_step(input logic [7:0] cnt, input logic up,
                                               input logic [7:0] cnt_max);
      if (up)
         return (cnt == cnt_max) ? cnt : cnt + 8'd1;
      else
         return (cnt == {6'd0, CNT_SNT}) ? cnt : cnt - 8'd1;
   endfunction

   function automatic int way_idx_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/btb_assoc_predictor_if.sv
// rtl/btb_assoc_predictor_if.sv - fetch/execute predictor bus; perf outputs under BP_PERF_CNT_EN
interface btb_assoc_predictor_if;
   logic [31:0] PC_F;
   logic        PrPCSrc_F;
   logic [31:0] PrALUResult_F;
   logic        PrHit_F;
   logic        Upd_E;
   logic [31:0] PC_E;
   logic        PCSrc_E;
   logic [31:0] ALUResult_E;
   logic        Flush;
`ifdef BP_PERF_CNT_EN
   logic [31:0] PerfUpd;
   logic [31:0] PerfHit;
   logic [31:0] PerfAlloc;
`endif

   modport slave (
      input  PC_F, Upd_E, PC_E, PCSrc_E, ALUResult_E, Flush,
      output PrPCSrc_F, PrALUResult_F, PrHit_F
`ifdef BP_PERF_CNT_EN
      , output PerfUpd, PerfHit, PerfAlloc
`endif
   );

   modport master (
      output PC_F, Upd_E, PC_E, PCSrc_E, ALUResult_E, Flush,
      input  PrPCSrc_F, PrALUResult_F, PrHit_F
`ifdef BP_PERF_CNT_EN
      , input PerfUpd, PerfHit, PerfAlloc
`endif
   );
endinterface

// File: rtl/btb_assoc_predictor_plru.sv
// rtl/btb_assoc_predictor_plru.sv - bp_plru: tree pseudo-LRU state for one set
// Each tree bit points toward the subtree holding the next victim.
module bp_plru
   import bp_pkg::*;
#(
   parameter  int WAYS = 2,
   localparam int WIDX = way_idx_bits(WAYS)
) (
   input  logic            clk,
   input  logic            RESET,
   input  logic            i_acc,
   input  logic [WIDX-1:0] i_way,
   output logic [WIDX-1:0] o_victim
);

   generate
      if (WAYS == 1) begin : g_w1
         logic w_unused_plru;
         assign w_unused_plru = ^{clk, RESET, i_acc, i_way};
         assign o_victim = '0;
      end else if (WAYS == 2) begin : g_w2
         logic r_bit;
         always_ff @(posedge clk or posedge RESET) begin
            if (RESET)      r_bit <= 1'b0;
            else if (i_acc) r_bit <= ~i_way[0];
         end
         assign o_victim = r_bit;
      end else begin : g_w4
         logic [2:0] r_bits;
         always_ff @(posedge clk or posedge RESET) begin
            if (RESET) begin
               r_bits <= 3'b000;
            end else if (i_acc) begin
               r_bits[0] <= ~i_way[1];
               if (i_way[1]) r_bits[2] <= ~i_way[0];
               else          r_bits[1] <= ~i_way[0];
            end
         end
         assign o_victim = r_bits[0] ? {1'b1, r_bits[2]} : {1'b0, r_bits[1]};
      end
   endgenerate

endmodule

// File: rtl/btb_assoc_predictor.sv
// rtl/btb_assoc_predictor.sv - set-associative BHT/BTB with tags, PLRU and flush
// Optional perf counters enabled by BP_PERF_CNT_EN.
module btb_assoc_predictor
   import bp_pkg::*;
#(
   parameter int ENTRY_BITS = 4,
   parameter int WAYS       = 2,
   parameter int PRD_BITS   = 2
) (
   input logic                  clk,
   input logic                  RESET,
   btb_assoc_predictor_if.slave bp
);

   localparam int SETS     = 2 ** ENTRY_BITS;
   localparam int TAG_BITS = 30 - ENTRY_BITS;
   localparam int WIDX     = way_idx_bits(WAYS);
   localparam logic [PRD_BITS-1:0] L_CNT_INIT  = (PRD_BITS == 2) ? PRD_BITS'(CNT_ALLOC_INIT)
                                                 : {1'b1, {(PRD_BITS-1){1'b0}}};
   localparam logic [PRD_BITS-1:0] L_CNT_RESET = (PRD_BITS == 2) ? PRD_BITS'(CNT_RESET)
                                                 : {1'b0, {(PRD_BITS-1){1'b1}}};
   localparam logic [PRD_BITS-1:0] L_CNT_MAX   = (PRD_BITS == 2) ? PRD_BITS'(CNT_ST) : '1;

   logic                r_valid [SETS][WAYS];
   logic [TAG_BITS-1:0] r_tag   [SETS][WAYS];
   logic [PRD_BITS-1:0] r_cnt   [SETS][WAYS];
   logic [31:0]         r_ta    [SETS][WAYS];

   logic [ENTRY_BITS-1:0] w_f_set, w_e_set;
   logic [TAG_BITS-1:0]   w_f_tag, w_e_tag;
   logic                  w_f_hit, w_e_hit, w_inv_any, w_pr_taken;
   logic [WIDX-1:0]       w_f_way, w_e_way, w_inv_way, w_victim, w_acc_way;
   logic [WIDX-1:0]       w_plru_victim [SETS];
   logic                  w_upd_ok, w_hit_upd, w_alloc;
   logic [7:0]            w_cnt_step;
   logic                  w_unused_bits;

   assign w_f_set = bp.PC_F[ENTRY_BITS+1:2];
   assign w_f_tag = bp.PC_F[31:ENTRY_BITS+2];
   assign w_e_set = bp.PC_E[ENTRY_BITS+1:2];
   assign w_e_tag = bp.PC_E[31:ENTRY_BITS+2];

   // Downward scans so the lowest-index matching or invalid way wins.
   always_comb begin
      w_f_hit   = 1'b0;
      w_f_way   = '0;
      w_e_hit   = 1'b0;
      w_e_way   = '0;
      w_inv_any = 1'b0;
      w_inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_f_set][w] && r_tag[w_f_set][w] == w_f_tag) begin
            w_f_hit = 1'b1;
            w_f_way = WIDX'(w);
         end
         if (r_valid[w_e_set][w] && r_tag[w_e_set][w] == w_e_tag) begin
            w_e_hit = 1'b1;
            w_e_way = WIDX'(w);
         end
         if (!r_valid[w_e_set][w]) begin
            w_inv_any = 1'b1;
            w_inv_way = WIDX'(w);
         end
      end
   end

   assign w_pr_taken       = w_f_hit & r_cnt[w_f_set][w_f_way][PRD_BITS-1];
   assign bp.PrHit_F       = w_f_hit;
   assign bp.PrPCSrc_F     = w_pr_taken;
   assign bp.PrALUResult_F = w_pr_taken ? r_ta[w_f_set][w_f_way] : 32'd0;

   assign w_upd_ok   = bp.Upd_E & ~bp.Flush;
   assign w_hit_upd  = w_upd_ok & w_e_hit;
   assign w_alloc    = w_upd_ok & ~w_e_hit & bp.PCSrc_E;
   assign w_victim   = w_inv_any ? w_inv_way : w_plru_victim[w_e_set];
   assign w_acc_way  = w_e_hit ? w_e_way : w_victim;
   assign w_cnt_step = cnt_sat_step(8'(r_cnt[w_e_set][w_e_way]), bp.PCSrc_E, 8'(L_CNT_MAX));
   assign w_unused_bits = ^{bp.PC_F[1:0], bp.PC_E[1:0], w_cnt_step[7:PRD_BITS]};

   generate
      for (genvar s = 0; s < SETS; s++) begin : g_plru
         bp_plru #(.WAYS(WAYS)) u_plru (
            .clk      (clk),
            .RESET    (RESET),
            .i_acc    ((w_hit_upd | w_alloc) && (w_e_set == ENTRY_BITS'(s))),
            .i_way    (w_acc_way),
            .o_victim (w_plru_victim[s])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_valid[s][w] <= 1'b0;
               r_tag[s][w]   <= '0;
               r_cnt[s][w]   <= L_CNT_RESET;
               r_ta[s][w]    <= 32'd0;
            end
         end
      end else if (bp.Flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               r_valid[s][w] <= 1'b0;
      end else if (w_hit_upd) begin
         r_cnt[w_e_set][w_e_way] <= w_cnt_step[PRD_BITS-1:0];
         if (bp.PCSrc_E) r_ta[w_e_set][w_e_way] <= bp.ALUResult_E;
      end else if (w_alloc) begin
         r_valid[w_e_set][w_victim] <= 1'b1;
         r_tag[w_e_set][w_victim]   <= w_e_tag;
         r_ta[w_e_set][w_victim]    <= bp.ALUResult_E;
         r_cnt[w_e_set][w_victim]   <= L_CNT_INIT;
      end
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] r_perf_upd, r_perf_hit, r_perf_alloc;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_perf_upd   <= 32'd0;
         r_perf_hit   <= 32'd0;
         r_perf_alloc <= 32'd0;
      end else if (w_upd_ok) begin
         if (r_perf_upd != 32'hFFFF_FFFF)               r_perf_upd   <= r_perf_upd + 32'd1;
         if (w_hit_upd && r_perf_hit != 32'hFFFF_FFFF)  r_perf_hit   <= r_perf_hit + 32'd1;
         if (w_alloc && r_perf_alloc != 32'hFFFF_FFFF)  r_perf_alloc <= r_perf_alloc + 32'd1;
      end
   end

   assign bp.PerfUpd   = r_perf_upd;
   assign bp.PerfHit   = r_perf_hit;
   assign bp.PerfAlloc = r_perf_alloc;
`endif

endmodule
